// File: rtl/column_fifo.sv
// column_fifo: show-ahead FIFO of COLUMN-word rows with occupancy count, level flags,
// synchronous flush and sticky overflow/underflow flags.
module column_fifo #(
  parameter int B = 8,
  parameter int W = 2,
  parameter int COLUMN = 3,
  parameter int AF_LEVEL = 2**W-1,
  parameter int AE_LEVEL = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [COLUMN-1:0][B-1:0] w_data,
  output logic [COLUMN-1:0][B-1:0] r_data,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [W:0]               count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int DEPTH = 2**W;
  logic [DEPTH-1:0][COLUMN-1:0][B-1:0] mem;
  logic [W-1:0] w_ptr, r_ptr;
  logic do_wr, do_rd;
  // A write on a full FIFO is still accepted when a read frees the head slot the same cycle
  always_comb begin
    do_wr = wr && (!full || rd);
    do_rd = rd && !empty;
    empty = count == '0;
    full = count == (W+1)'(DEPTH);
    almost_empty = count <= (W+1)'(AE_LEVEL);
    almost_full = count >= (W+1)'(AF_LEVEL);
    r_data = mem[r_ptr];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem <= '0;
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_wr) begin
        mem[w_ptr] <= w_data;
        w_ptr <= w_ptr + W'(1);
      end
      if (do_rd) r_ptr <= r_ptr + W'(1);
      count <= count + (W+1)'(do_wr) - (W+1)'(do_rd);
      if (wr && !do_wr) overflow <= 1'b1;
      if (rd && empty) underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_column_fifo.sv
// tb_column_fifo: directed scenarios for column_fifo with hand-computed expectations.
module tb_column_fifo;
  typedef logic [2:0][7:0] row_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clr = 1'b0, wr = 1'b0, rd = 1'b0;
  row_t w_data = '0;
  row_t r_data;
  logic empty, full, almost_empty, almost_full, overflow, underflow;
  logic [2:0] count;
  int tests = 0;
  int fails = 0;

  column_fifo #(.B(8), .W(2), .COLUMN(3), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk(clk), .reset(reset), .clr(clr), .wr(wr), .rd(rd), .w_data(w_data),
    .r_data(r_data), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic row_t mk(input int a, input int b, input int c);
    return {8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic cyc(input logic c, input logic w, input logic r, input row_t d);
    @(negedge clk);
    clr = c; wr = w; rd = r; w_data = d;
    @(posedge clk);
    #1;
    clr = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  task automatic test_reset;
    cyc(0, 1, 0, mk(9, 9, 9));
    @(negedge clk);
    #1 reset = 1'b0;
    #2;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL rst_count got %0d want 0", count); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL rst_empty got %b want 1", empty); end
    tests++; if (almost_empty !== 1'b1) begin fails++; $display("FAIL rst_almost_empty got %b want 1", almost_empty); end
    tests++; if (full !== 1'b0 || almost_full !== 1'b0) begin fails++; $display("FAIL rst_full got %b/%b want 0/0", full, almost_full); end
    tests++; if (r_data !== 24'h0) begin fails++; $display("FAIL rst_rdata got %h want 000000", r_data); end
    tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin fails++; $display("FAIL rst_err got %b/%b want 0/0", overflow, underflow); end
    #1 reset = 1'b1;
  endtask

  task automatic test_fill_drain;
    cyc(0, 1, 0, mk(1, 2, 3));
    tests++; if (count !== 3'd1 || empty !== 1'b0 || almost_empty !== 1'b1) begin fails++; $display("FAIL fd_w1 got cnt=%0d e=%b ae=%b want 1/0/1", count, empty, almost_empty); end
    tests++; if (r_data !== mk(1, 2, 3)) begin fails++; $display("FAIL fd_head1 got %h want %h", r_data, mk(1, 2, 3)); end
    cyc(0, 1, 0, mk(4, 5, 6));
    tests++; if (almost_empty !== 1'b0 || almost_full !== 1'b0) begin fails++; $display("FAIL fd_w2 got ae=%b af=%b want 0/0", almost_empty, almost_full); end
    cyc(0, 1, 0, mk(7, 8, 9));
    tests++; if (almost_full !== 1'b1 || full !== 1'b0 || count !== 3'd3) begin fails++; $display("FAIL fd_w3 got af=%b f=%b cnt=%0d want 1/0/3", almost_full, full, count); end
    cyc(0, 1, 0, mk(10, 11, 12));
    tests++; if (count !== 3'd4 || full !== 1'b1) begin fails++; $display("FAIL fd_w4 got cnt=%0d f=%b want 4/1", count, full); end
    cyc(0, 1, 0, mk(13, 14, 15));
    tests++; if (count !== 3'd4 || overflow !== 1'b1) begin fails++; $display("FAIL fd_ovf got cnt=%0d ovf=%b want 4/1", count, overflow); end
    for (int k = 0; k < 4; k++) begin
      tests++; if (r_data !== mk(3*k+1, 3*k+2, 3*k+3)) begin fails++; $display("FAIL fd_rd%0d got %h want %h", k, r_data, mk(3*k+1, 3*k+2, 3*k+3)); end
      cyc(0, 0, 1, '0);
    end
    tests++; if (empty !== 1'b1 || almost_empty !== 1'b1 || count !== 3'd0) begin fails++; $display("FAIL fd_end got e=%b ae=%b cnt=%0d want 1/1/0", empty, almost_empty, count); end
    tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL fd_unf got %b want 0", underflow); end
  endtask

  task automatic test_wrap;
    for (int k = 0; k < 10; k++) begin
      cyc(0, 1, 0, mk(k+20, k+21, k+22));
      tests++; if (count !== 3'd1 || r_data !== mk(k+20, k+21, k+22)) begin fails++; $display("FAIL wrap_w%0d got cnt=%0d %h want 1 %h", k, count, r_data, mk(k+20, k+21, k+22)); end
      cyc(0, 0, 1, '0);
      tests++; if (count !== 3'd0) begin fails++; $display("FAIL wrap_r%0d got cnt=%0d want 0", k, count); end
    end
  endtask

  task automatic test_simultaneous;
    cyc(1, 0, 0, '0);
    cyc(0, 1, 1, mk(40, 41, 42));
    tests++; if (count !== 3'd1 || underflow !== 1'b1) begin fails++; $display("FAIL sim_empty got cnt=%0d unf=%b want 1/1", count, underflow); end
    tests++; if (r_data !== mk(40, 41, 42)) begin fails++; $display("FAIL sim_empty_head got %h want %h", r_data, mk(40, 41, 42)); end
    cyc(0, 1, 0, mk(43, 44, 45));
    cyc(0, 1, 0, mk(46, 47, 48));
    cyc(0, 1, 0, mk(49, 50, 51));
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL sim_fill got f=%b want 1", full); end
    cyc(0, 1, 1, mk(52, 53, 54));
    tests++; if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin fails++; $display("FAIL sim_full got cnt=%0d f=%b ovf=%b want 4/1/0", count, full, overflow); end
    for (int k = 0; k < 4; k++) begin
      tests++; if (r_data !== mk(3*k+43, 3*k+44, 3*k+45)) begin fails++; $display("FAIL sim_rd%0d got %h want %h", k, r_data, mk(3*k+43, 3*k+44, 3*k+45)); end
      cyc(0, 0, 1, '0);
    end
  endtask

  task automatic test_flush;
    for (int k = 0; k < 5; k++) cyc(0, 1, 0, mk(60+k, 61+k, 62+k));
    cyc(0, 0, 1, '0);
    tests++; if (count !== 3'd3 || overflow !== 1'b1) begin fails++; $display("FAIL fl_pre got cnt=%0d ovf=%b want 3/1", count, overflow); end
    cyc(1, 1, 0, mk(99, 99, 99));
    tests++; if (count !== 3'd0 || empty !== 1'b1) begin fails++; $display("FAIL fl_count got cnt=%0d e=%b want 0/1", count, empty); end
    tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin fails++; $display("FAIL fl_err got %b/%b want 0/0", overflow, underflow); end
    cyc(0, 0, 0, '0);
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL fl_discard got cnt=%0d want 0", count); end
  endtask

  task automatic test_async_reset;
    cyc(0, 1, 0, mk(70, 71, 72));
    cyc(0, 1, 0, mk(73, 74, 75));
    tests++; if (count !== 3'd2) begin fails++; $display("FAIL ar_pre got cnt=%0d want 2", count); end
    @(negedge clk);
    #1 reset = 1'b0;
    #2;
    tests++; if (count !== 3'd0 || empty !== 1'b1 || almost_empty !== 1'b1) begin fails++; $display("FAIL ar_flags got cnt=%0d e=%b ae=%b want 0/1/1", count, empty, almost_empty); end
    tests++; if (r_data !== 24'h0) begin fails++; $display("FAIL ar_rdata got %h want 000000", r_data); end
    #1 reset = 1'b1;
    cyc(0, 1, 0, mk(80, 81, 82));
    tests++; if (count !== 3'd1 || r_data !== mk(80, 81, 82)) begin fails++; $display("FAIL ar_post got cnt=%0d %h want 1 %h", count, r_data, mk(80, 81, 82)); end
  endtask

  initial begin
    #3 reset = 1'b1;
    test_reset;
    test_fill_drain;
    test_wrap;
    test_simultaneous;
    test_flush;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
